seq_code_lock: RTL and testbench

//  Parametrised switch-sequence combination lock for the board I/O layer. Detects rising edges on NUM_IN

---
 rtl/lock_pkg.sv | 35 +++
 rtl/lock_msg_display.sv | 39 +++
 rtl/seq_code_lock.sv | 266 ++++++++++++++++++++++++++
 tb/tb_seq_code_lock.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/lock_pkg.sv
// Shared types and constants for the seq_code_lock slice.
// state_t is also driven out on seq_code_lock.state_o, so its encoding is visible at the board level.
package lock_pkg;

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      ENTRY   = 3'd1,
      OPEN    = 3'd2,
      FAIL    = 3'd3,
      LOCKOUT = 3'd4,
      ENROLL  = 3'd5
   } state_t;

   // 7-segment glyphs, bit order gfedcba, active-low (0 lights the segment)
   localparam logic [6:0] SEG_BLANK = 7'h7F;
   localparam logic [6:0] SEG_D     = 7'h21;  // d
   localparam logic [6:0] SEG_O_LC  = 7'h23;  // o
   localparam logic [6:0] SEG_N     = 7'h2B;  // n
   localparam logic [6:0] SEG_E     = 7'h06;  // E
   localparam logic [6:0] SEG_R     = 7'h2F;  // r
   localparam logic [6:0] SEG_L     = 7'h47;  // L
   localparam logic [6:0] SEG_O_UC  = 7'h40;  // O
   localparam logic [6:0] SEG_C     = 7'h46;  // C
   localparam logic [6:0] SEG_P     = 7'h0C;  // P
   localparam logic [6:0] SEG_G     = 7'h10;  // g

   // largest of three cycle counts, used to size the shared timer
   function automatic int unsigned max3(input int unsigned a, input int unsigned b,
                                        input int unsigned c);
      int unsigned m;
      m = (a > b) ? a : b;
      return (m > c) ? m : c;
   endfunction

endpackage

// File: rtl/lock_msg_display.sv
// Registered state-to-message mapping for the five active-low 7-segment digits.
// hex4_o is the leftmost digit; messages are right-justified.
module lock_msg_display
   import lock_pkg::*;
(
   input  logic       clk,
   input  logic       reset,
   input  state_t     state,
   output logic [6:0] hex0_o,
   output logic [6:0] hex1_o,
   output logic [6:0] hex2_o,
   output logic [6:0] hex3_o,
   output logic [6:0] hex4_o
);

   logic [34:0] msg;

   // pick the glyph string for the current state, {hex4 .. hex0}
   always_comb begin
      msg = {5{SEG_BLANK}};
      case (state)
         OPEN:    msg = {SEG_BLANK, SEG_D, SEG_O_LC, SEG_N, SEG_E};
         FAIL:    msg = {SEG_E, SEG_R, SEG_R, SEG_O_LC, SEG_R};
         LOCKOUT: msg = {SEG_BLANK, SEG_BLANK, SEG_L, SEG_O_UC, SEG_C};
         ENROLL:  msg = {SEG_BLANK, SEG_P, SEG_R, SEG_O_LC, SEG_G};
         default: msg = {5{SEG_BLANK}};
      endcase
   end

   // register the digits so they change together with the other status outputs
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         {hex4_o, hex3_o, hex2_o, hex1_o, hex0_o} <= {5{SEG_BLANK}};
      end else begin
         {hex4_o, hex3_o, hex2_o, hex1_o, hex0_o} <= msg;
      end
   end

endmodule

// File: rtl/seq_code_lock.sv
// Switch-sequence combination lock: synchronises the switches, detects rising edges,
// checks them against a CODE_LEN-entry code, and locks out after MAX_FAIL consecutive failures.
// Optional feature macro: CODE_ENROLL_EN (code re-programming from the OPEN state).
module seq_code_lock
   import lock_pkg::*;
#(
   parameter int unsigned NUM_IN         = 8,
   parameter int unsigned CODE_LEN       = 4,
   parameter              DEFAULT_CODE   = 'h3210,
   parameter int unsigned MAX_FAIL       = 3,
   parameter int unsigned RESULT_CYCLES  = 25_000_000,
   parameter int unsigned LOCKOUT_CYCLES = 250_000_000,
   parameter int unsigned ENTRY_TIMEOUT  = 150_000_000
) (
   input  logic                clk,
   input  logic                reset,
   input  logic [NUM_IN-1:0]   sw_i,
   input  logic                enroll_i,
   output logic [CODE_LEN-1:0] progress_o,
   output logic                unlocked_o,
   output logic                alarm_o,
   output logic [2:0]          state_o,
   output logic [6:0]          hex0_o,
   output logic [6:0]          hex1_o,
   output logic [6:0]          hex2_o,
   output logic [6:0]          hex3_o,
   output logic [6:0]          hex4_o
);

   localparam int unsigned IDX_W   = (NUM_IN > 1) ? $clog2(NUM_IN) : 1;
   localparam int unsigned CODE_W  = CODE_LEN * IDX_W;
   localparam int unsigned CNT_W   = $clog2(CODE_LEN + 1);
   localparam int unsigned FAIL_W  = $clog2(MAX_FAIL + 1);
   localparam int unsigned TMR_MAX = max3(RESULT_CYCLES, LOCKOUT_CYCLES, ENTRY_TIMEOUT);
   localparam int unsigned TMR_W   = $clog2(TMR_MAX + 1);

   localparam logic [CODE_W-1:0] DEF_CODE   = CODE_W'(DEFAULT_CODE);
   localparam logic [TMR_W-1:0]  RES_LAST   = TMR_W'(RESULT_CYCLES - 1);
   localparam logic [TMR_W-1:0]  LOCK_LAST  = TMR_W'(LOCKOUT_CYCLES - 1);
   localparam logic [TMR_W-1:0]  ENTRY_LAST = TMR_W'(ENTRY_TIMEOUT);

   state_t              state;
   logic [CNT_W-1:0]    idx;
   logic [CNT_W-1:0]    idx_nxt;
   logic [TMR_W-1:0]    timer;
   logic [TMR_W-1:0]    tmr_inc;
   logic [FAIL_W-1:0]   fail_cnt;
   logic [FAIL_W-1:0]   fail_nxt;
   logic [CODE_W-1:0]   cur_code;

   logic [NUM_IN-1:0]   sync1;
   logic [NUM_IN-1:0]   sync2;
   logic [NUM_IN-1:0]   prev;
   logic                primed;
   logic [NUM_IN-1:0]   sw_edge;
   logic                any_edge;
   logic                single_edge;
   logic [IDX_W-1:0]    edge_idx;
   logic                hit;
   logic                last_entry;

   function automatic logic [IDX_W-1:0] code_at(input logic [CODE_W-1:0] c,
                                                input logic [CNT_W-1:0]  k);
      return c[int'(k) * IDX_W +: IDX_W];
   endfunction

   function automatic logic [CODE_LEN-1:0] thermo(input logic [CNT_W-1:0] n);
      logic [CODE_LEN-1:0] m;
      m = '0;
      for (int unsigned k = 0; k < CODE_LEN; k++) m[k] = (CNT_W'(k) < n);
      return m;
   endfunction

`ifdef CODE_ENROLL_EN
   logic [CODE_W-1:0] code;
   logic [CODE_W-1:0] new_code;
   logic [CODE_W-1:0] staged;

   assign cur_code = code;

   // new code image with the current edge written at position idx
   always_comb begin
      staged = new_code;
      staged[int'(idx) * IDX_W +: IDX_W] = edge_idx;
   end
`else
   logic unused_enroll;

   assign cur_code      = DEF_CODE;
   assign unused_enroll = enroll_i;
`endif

   // 2-FF synchroniser, kept out of reset so it tracks the switches while reset is held
   always_ff @(posedge clk) begin
      sync1 <= sw_i;
      sync2 <= sync1;
   end

   // edge-detect history; the first cycle after reset only loads prev
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         prev   <= '0;
         primed <= 1'b0;
      end else begin
         prev   <= sync2;
         primed <= 1'b1;
      end
   end

   assign sw_edge     = primed ? (sync2 & ~prev) : '0;
   assign any_edge    = |sw_edge;
   assign single_edge = $onehot(sw_edge);

   // binary index of the (single) rising edge
   always_comb begin
      edge_idx = '0;
      for (int unsigned i = 0; i < NUM_IN; i++) begin
         if (sw_edge[i]) edge_idx = IDX_W'(i);
      end
   end

   assign idx_nxt    = idx + 1'b1;
   assign last_entry = (idx_nxt == CNT_W'(CODE_LEN));
   assign hit        = single_edge && (edge_idx == code_at(cur_code, idx));
   assign tmr_inc    = (timer == '1) ? timer : timer + 1'b1;
   assign fail_nxt   = fail_cnt + 1'b1;

   // main lock FSM: state, entry index, shared saturating timer, failure count, code register
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state    <= IDLE;
         idx      <= '0;
         timer    <= '0;
         fail_cnt <= '0;
`ifdef CODE_ENROLL_EN
         code     <= DEF_CODE;
         new_code <= DEF_CODE;
`endif
      end else begin
         case (state)
            // IDLE is ENTRY with idx==0 and no timeout, so both share one branch
            IDLE, ENTRY: begin
               if (any_edge) begin
                  timer <= '0;
                  if (!hit) begin
                     state <= FAIL;
                     idx   <= '0;
                  end else if (last_entry) begin
                     state    <= OPEN;
                     idx      <= '0;
                     fail_cnt <= '0;
                  end else begin
                     state <= ENTRY;
                     idx   <= idx_nxt;
                  end
               end else if (state == ENTRY) begin
                  if (timer == ENTRY_LAST) begin
                     state <= FAIL;
                     idx   <= '0;
                     timer <= '0;
                  end else begin
                     timer <= tmr_inc;
                  end
               end
            end

            OPEN: begin
`ifdef CODE_ENROLL_EN
               if (enroll_i) begin
                  state    <= ENROLL;
                  idx      <= '0;
                  timer    <= '0;
                  new_code <= code;
               end else
`endif
               if (timer == RES_LAST) begin
                  state <= IDLE;
                  timer <= '0;
               end else begin
                  timer <= tmr_inc;
               end
            end

            FAIL: begin
               if (timer == RES_LAST) begin
                  timer    <= '0;
                  fail_cnt <= fail_nxt;
                  state    <= (fail_nxt == FAIL_W'(MAX_FAIL)) ? LOCKOUT : IDLE;
               end else begin
                  timer <= tmr_inc;
               end
            end

            LOCKOUT: begin
               if (timer == LOCK_LAST) begin
                  state    <= IDLE;
                  timer    <= '0;
                  fail_cnt <= '0;
               end else begin
                  timer <= tmr_inc;
               end
            end

`ifdef CODE_ENROLL_EN
            ENROLL: begin
               if (any_edge) begin
                  timer <= '0;
                  if (!single_edge) begin
                     state <= FAIL;
                     idx   <= '0;
                  end else if (last_entry) begin
                     code  <= staged;
                     state <= IDLE;
                     idx   <= '0;
                  end else begin
                     new_code <= staged;
                     idx      <= idx_nxt;
                  end
               end else if (timer == ENTRY_LAST) begin
                  state <= FAIL;
                  idx   <= '0;
                  timer <= '0;
               end else begin
                  timer <= tmr_inc;
               end
            end
`endif

            default: begin
               state <= IDLE;
               idx   <= '0;
               timer <= '0;
            end
         endcase
      end
   end

   // registered status outputs, one cycle behind the state register
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         progress_o <= '0;
         unlocked_o <= 1'b0;
         alarm_o    <= 1'b0;
         state_o    <= '0;
      end else begin
         if (state == ENTRY || state == ENROLL) progress_o <= thermo(idx);
         else if (state == OPEN)                progress_o <= '1;
         else                                   progress_o <= '0;
         unlocked_o <= (state == OPEN);
         alarm_o    <= (state == LOCKOUT);
         state_o    <= state;
      end
   end

   lock_msg_display u_display (
      .clk    (clk),
      .reset  (reset),
      .state  (state),
      .hex0_o (hex0_o),
      .hex1_o (hex1_o),
      .hex2_o (hex2_o),
      .hex3_o (hex3_o),
      .hex4_o (hex4_o)
   );

endmodule

// File: tb/tb_seq_code_lock.sv
// Directed bench for seq_code_lock with short timing parameters and code 0,1,2,3.
// A press raises one switch for a cycle; its effect reaches the registered outputs 4 cycles later.
module tb_seq_code_lock;

   localparam logic [11:0] TB_CODE = {3'd3, 3'd2, 3'd1, 3'd0};

   localparam logic [2:0] S_IDLE = 3'd0;
   localparam logic [2:0] S_ENTRY = 3'd1;
   localparam logic [2:0] S_OPEN = 3'd2;
   localparam logic [2:0] S_FAIL = 3'd3;
   localparam logic [2:0] S_LOCK = 3'd4;
   localparam logic [2:0] S_PROG = 3'd5;

   localparam logic [34:0] H_BLANK = {5{7'h7F}};
   localparam logic [34:0] H_DONE  = {7'h7F, 7'h21, 7'h23, 7'h2B, 7'h06};
   localparam logic [34:0] H_ERROR = {7'h06, 7'h2F, 7'h2F, 7'h23, 7'h2F};
   localparam logic [34:0] H_LOC   = {7'h7F, 7'h7F, 7'h47, 7'h40, 7'h46};
   localparam logic [34:0] H_PROG  = {7'h7F, 7'h0C, 7'h2F, 7'h23, 7'h10};

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic [7:0] sw = '0;
   logic       enroll = 1'b0;
   logic [3:0] progress_o;
   logic       unlocked_o, alarm_o;
   logic [2:0] state_o;
   logic [6:0] hex0_o, hex1_o, hex2_o, hex3_o, hex4_o;

   int checks = 0;
   int errors = 0;
   int base;

   typedef struct {
      logic [7:0] sw;
      logic       en;
      int         n;
      logic       chk;
      logic [2:0] st;
      logic [3:0] prog;
   } vec_t;

   vec_t vecs[$];

   seq_code_lock #(
      .NUM_IN         (8),
      .CODE_LEN       (4),
      .DEFAULT_CODE   (TB_CODE),
      .MAX_FAIL       (3),
      .RESULT_CYCLES  (4),
      .LOCKOUT_CYCLES (16),
      .ENTRY_TIMEOUT  (10)
   ) dut (
      .clk        (clk),
      .reset      (reset),
      .sw_i       (sw),
      .enroll_i   (enroll),
      .progress_o (progress_o),
      .unlocked_o (unlocked_o),
      .alarm_o    (alarm_o),
      .state_o    (state_o),
      .hex0_o     (hex0_o),
      .hex1_o     (hex1_o),
      .hex2_o     (hex2_o),
      .hex3_o     (hex3_o),
      .hex4_o     (hex4_o)
   );

   always #5 clk = ~clk;

   function automatic logic [34:0] hex_for(input logic [2:0] st);
      case (st)
         S_OPEN:  return H_DONE;
         S_FAIL:  return H_ERROR;
         S_LOCK:  return H_LOC;
         S_PROG:  return H_PROG;
         default: return H_BLANK;
      endcase
   endfunction

   task automatic check(input string name, input logic [34:0] act, input logic [34:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic check_outputs(input string tag, input logic [2:0] st, input logic [3:0] prog);
      check({tag, " state"},    35'(state_o),    35'(st));
      check({tag, " progress"}, 35'(progress_o), 35'(prog));
      check({tag, " unlocked"}, 35'(unlocked_o), 35'(st == S_OPEN));
      check({tag, " alarm"},    35'(alarm_o),    35'(st == S_LOCK));
      check({tag, " hex"}, {hex4_o, hex3_o, hex2_o, hex1_o, hex0_o}, hex_for(st));
   endtask

   task automatic add(input logic [7:0] sw_v, input logic en_v, input int n_v,
                      input logic chk_v, input logic [2:0] st_v, input logic [3:0] prog_v);
      vec_t v;
      v.sw = sw_v; v.en = en_v; v.n = n_v; v.chk = chk_v; v.st = st_v; v.prog = prog_v;
      vecs.push_back(v);
   endtask

   task automatic press(input int i, input logic [2:0] st_v, input logic [3:0] prog_v);
      add(8'h01 << i, 1'b0, 1, 1'b0, S_IDLE, 4'h0);
      add(8'h00, 1'b0, 3, 1'b1, st_v, prog_v);
   endtask

   task automatic hold(input int n_v, input logic en_v, input logic [2:0] st_v,
                       input logic [3:0] prog_v);
      add(8'h00, en_v, n_v, 1'b1, st_v, prog_v);
   endtask

   task automatic enter_code(input int a, input int b, input int c, input int d);
      press(a, S_ENTRY, 4'b0001);
      press(b, S_ENTRY, 4'b0011);
      press(c, S_ENTRY, 4'b0111);
      press(d, S_OPEN, 4'b1111);
   endtask

   task automatic open_code(input int a, input int b, input int c, input int d);
      enter_code(a, b, c, d);
      hold(3, 1'b0, S_OPEN, 4'b1111);
      hold(1, 1'b0, S_IDLE, 4'h0);
   endtask

   initial begin
      // build the vector table
      hold(2, 1'b0, S_IDLE, 4'h0);
      // correct code, full OPEN window
      open_code(0, 1, 2, 3);
      // wrong third entry, then a correct code
      press(0, S_ENTRY, 4'b0001);
      press(1, S_ENTRY, 4'b0011);
      press(5, S_FAIL, 4'h0);
      hold(3, 1'b0, S_FAIL, 4'h0);
      hold(1, 1'b0, S_IDLE, 4'h0);
      open_code(0, 1, 2, 3);
      // three failures -> lockout; correct code inside lockout ignored
      press(5, S_FAIL, 4'h0);
      hold(4, 1'b0, S_IDLE, 4'h0);
      press(5, S_FAIL, 4'h0);
      hold(4, 1'b0, S_IDLE, 4'h0);
      press(5, S_FAIL, 4'h0);
      hold(4, 1'b0, S_LOCK, 4'h0);
      press(0, S_LOCK, 4'h0);
      press(1, S_LOCK, 4'h0);
      press(2, S_LOCK, 4'h0);
      add(8'h08, 1'b0, 1, 1'b0, S_IDLE, 4'h0);
      hold(2, 1'b0, S_LOCK, 4'h0);
      hold(1, 1'b0, S_IDLE, 4'h0);
      open_code(0, 1, 2, 3);
      // entry timeout
      press(0, S_ENTRY, 4'b0001);
      hold(10, 1'b0, S_ENTRY, 4'b0001);
      hold(1, 1'b0, S_FAIL, 4'h0);
      hold(3, 1'b0, S_FAIL, 4'h0);
      hold(1, 1'b0, S_IDLE, 4'h0);
      // two switches rising together
      add(8'h03, 1'b0, 1, 1'b0, S_IDLE, 4'h0);
      hold(3, 1'b0, S_FAIL, 4'h0);
      hold(4, 1'b0, S_IDLE, 4'h0);
      open_code(0, 1, 2, 3);
`ifdef CODE_ENROLL_EN
      // enroll 7,6,5,4
      enter_code(0, 1, 2, 3);
      hold(2, 1'b1, S_PROG, 4'h0);
      press(7, S_PROG, 4'b0001);
      press(6, S_PROG, 4'b0011);
      press(5, S_PROG, 4'b0111);
      press(4, S_IDLE, 4'h0);
      open_code(4, 5, 6, 7);
      press(0, S_FAIL, 4'h0);
      hold(4, 1'b0, S_IDLE, 4'h0);
      // aborted enroll keeps 4,5,6,7
      enter_code(4, 5, 6, 7);
      hold(2, 1'b1, S_PROG, 4'h0);
      press(0, S_PROG, 4'b0001);
      add(8'h03, 1'b0, 1, 1'b0, S_IDLE, 4'h0);
      hold(3, 1'b0, S_FAIL, 4'h0);
      hold(4, 1'b0, S_IDLE, 4'h0);
      open_code(4, 5, 6, 7);
      base = 4;
`else
      base = 0;
`endif

      // reset state
      repeat (3) @(negedge clk);
      check_outputs("reset", S_IDLE, 4'h0);
      reset = 1'b0;

      foreach (vecs[i]) begin
         sw = vecs[i].sw;
         enroll = vecs[i].en;
         repeat (vecs[i].n) @(negedge clk);
         if (vecs[i].chk) check_outputs($sformatf("vec%0d", i), vecs[i].st, vecs[i].prog);
      end

      // reset in the middle of an attempt with the first two switches held high
      sw = 8'h01 << base;
      repeat (4) @(negedge clk);
      check_outputs("hold1", S_ENTRY, 4'b0001);
      sw = 8'h03 << base;
      repeat (4) @(negedge clk);
      check_outputs("hold2", S_ENTRY, 4'b0011);
      reset = 1'b1;
      #1;
      check_outputs("async rst", S_IDLE, 4'h0);
      repeat (3) @(negedge clk);
      reset = 1'b0;
      repeat (6) @(negedge clk);
      check_outputs("no phantom", S_IDLE, 4'h0);
      sw = 8'h00;
      repeat (4) @(negedge clk);
      check_outputs("falling", S_IDLE, 4'h0);
      // code is back to 0,1,2,3 after reset
      sw = 8'h01;
      @(negedge clk);
      sw = 8'h00;
      repeat (3) @(negedge clk);
      check_outputs("code revert", S_ENTRY, 4'b0001);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
